// File: rtl/aes_ahb_regbank.sv
// aes_ahb_regbank: AHB-Lite slave register bank for the AES core.
// NUM_CH job descriptors, start pulses, per-channel status and irq.
module aes_ahb_regbank #(
  parameter logic [22:0] BASE_HI   = 23'h0,
  parameter int          NUM_CH    = 2,
  parameter int          KEY_WORDS = 4
) (
  input  logic                           hclk,
  input  logic                           hresetn,
  input  logic                           hsel,
  input  logic [31:0]                    haddr,
  input  logic [1:0]                     htrans,
  input  logic                           hwrite,
  input  logic [2:0]                     hsize,
  input  logic                           hready,
  input  logic [31:0]                    hwdata,
  output logic                           hreadyout,
  output logic                           hresp,
  output logic [31:0]                    hrdata,
  output logic [NUM_CH-1:0]              ch_start,
  output logic [32*NUM_CH-1:0]           ch_src,
  output logic [32*NUM_CH-1:0]           ch_dst,
  output logic [32*KEY_WORDS*NUM_CH-1:0] ch_key,
  output logic [32*NUM_CH-1:0]           ch_size,
  output logic [NUM_CH-1:0]              ch_decrypt,
  input  logic [NUM_CH-1:0]              core_done,
  input  logic [NUM_CH-1:0]              core_err,
  output logic                           irq
);

  localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int KIW = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_WAIT, S_RD, S_ERR1, S_ERR2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] src_q  [NUM_CH];
  logic [31:0] dst_q  [NUM_CH];
  logic [31:0] size_q [NUM_CH];
  logic [31:0] key_q  [NUM_CH][KEY_WORDS];

  logic [NUM_CH-1:0] dec_q, ien_q;
  logic [NUM_CH-1:0] busy_q, done_q, err_q, start_q;
  logic [NUM_CH-1:0] busy_nxt, done_nxt, err_nxt;
  logic [NUM_CH-1:0] start_set, lock_set;

  logic [5:0]     d_off;
  logic [2:0]     d_chn;
  logic [CW-1:0]  d_ch;
  logic [KIW-1:0] d_kidx;
  logic d_src, d_dst, d_key, d_size, d_ctrl, d_stat;
  logic d_bad, d_lock;

  logic [CW-1:0]  a_ch;
  logic [KIW-1:0] a_kidx;
  logic a_src, a_dst, a_key, a_size, a_ctrl, a_stat;

  logic        ready_o, acc, wr;
  logic [31:0] rd_val;
  logic        unused_ok;

  assign unused_ok = htrans[0];

  assign ready_o   = (state != S_RD_WAIT) && (state != S_ERR1);
  assign acc       = hsel & hready & htrans[1] & ready_o;
  assign wr        = (state == S_WR);
  assign hreadyout = ready_o;
  assign hresp     = (state == S_ERR1) || (state == S_ERR2);

  // address-phase decode; busy lock looks at next-cycle BUSY
  always_comb begin
    d_off  = haddr[5:0];
    d_chn  = haddr[8:6];
    d_ch   = haddr[6 +: CW];
    d_src  = (d_off == 6'h00);
    d_dst  = (d_off == 6'h04);
    d_size = (d_off == 6'h28);
    d_ctrl = (d_off == 6'h2C);
    d_stat = (d_off == 6'h30);
    d_key  = 1'b0;
    d_kidx = '0;
    for (int k = 0; k < KEY_WORDS; k++) begin
      if (d_off == 6'(8 + 4*k)) begin
        d_key  = 1'b1;
        d_kidx = KIW'(k);
      end
    end
    d_bad = (haddr[31:9] != BASE_HI)
          | (int'(d_chn) >= NUM_CH)
          | ~(d_src | d_dst | d_key | d_size | d_ctrl | d_stat)
          | (hsize != 3'b010);
    d_lock = hwrite & ~d_bad & ~d_stat & busy_nxt[d_ch];
  end

  // data-phase state register
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // next data phase: wait/error sequencing or newly accepted transfer
  always_comb begin
    state_nxt = S_IDLE;
    unique case (state)
      S_RD_WAIT: state_nxt = S_RD;
      S_ERR1:    state_nxt = S_ERR2;
      default: begin
        if (acc) begin
          if (d_bad | d_lock) state_nxt = S_ERR1;
          else if (hwrite)    state_nxt = S_WR;
          else                state_nxt = S_RD_WAIT;
        end
      end
    endcase
  end

  // hold the decoded target for the data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      a_ch   <= '0;
      a_kidx <= '0;
      a_src  <= 1'b0;
      a_dst  <= 1'b0;
      a_key  <= 1'b0;
      a_size <= 1'b0;
      a_ctrl <= 1'b0;
      a_stat <= 1'b0;
    end else if (acc) begin
      a_ch   <= d_ch;
      a_kidx <= d_kidx;
      a_src  <= d_src;
      a_dst  <= d_dst;
      a_key  <= d_key;
      a_size <= d_size;
      a_ctrl <= d_ctrl;
      a_stat <= d_stat;
    end
  end

  // lock violations flag ERR on the channel they targeted
  always_comb begin
    lock_set = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc && d_lock && d_ch == CW'(c)) lock_set[c] = 1'b1;
    end
  end

  // status next-state: start beats done-clear, hw set beats W1C
  always_comb begin
    start_set = '0;
    busy_nxt  = busy_q;
    done_nxt  = done_q;
    err_nxt   = err_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr && a_ch == CW'(c)) begin
        if (a_ctrl && hwdata[0]) start_set[c] = 1'b1;
        if (a_stat && hwdata[1]) done_nxt[c] = 1'b0;
        if (a_stat && hwdata[2]) err_nxt[c] = 1'b0;
      end
      if (core_done[c] | core_err[c]) busy_nxt[c] = 1'b0;
      if (start_set[c]) busy_nxt[c] = 1'b1;
      if (core_done[c]) done_nxt[c] = 1'b1;
      if (core_err[c])  err_nxt[c] = 1'b1;
    end
  end

  // status, start pulse and registered interrupt
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      busy_q  <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= '0;
      irq     <= 1'b0;
    end else begin
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt | lock_set;
      start_q <= start_set;
      irq     <= |(ien_q & (done_q | err_q));
    end
  end

  // descriptor registers commit at the end of a write data phase
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      for (int c = 0; c < NUM_CH; c++) begin
        src_q[c]  <= '0;
        dst_q[c]  <= '0;
        size_q[c] <= '0;
        for (int k = 0; k < KEY_WORDS; k++) key_q[c][k] <= '0;
      end
      dec_q <= '0;
      ien_q <= '0;
    end else if (wr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (a_ch == CW'(c)) begin
          if (a_src)  src_q[c]  <= hwdata;
          if (a_dst)  dst_q[c]  <= hwdata;
          if (a_size) size_q[c] <= hwdata;
          if (a_key)  key_q[c][a_kidx] <= hwdata;
          if (a_ctrl) begin
            dec_q[c] <= hwdata[1];
            ien_q[c] <= hwdata[2];
          end
        end
      end
    end
  end

  // read mux for the registered read data
  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      a_src:   rd_val = src_q[a_ch];
      a_dst:   rd_val = dst_q[a_ch];
      a_size:  rd_val = size_q[a_ch];
      a_key:   rd_val = key_q[a_ch][a_kidx];
      a_ctrl:  rd_val = {29'd0, ien_q[a_ch], dec_q[a_ch], 1'b0};
      a_stat:  rd_val = {29'd0, err_q[a_ch], done_q[a_ch], busy_q[a_ch]};
      default: rd_val = '0;
    endcase
  end

  // read data captured during the wait state
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                hrdata <= '0;
    else if (state == S_RD_WAIT) hrdata <= rd_val;
  end

  // flatten descriptors onto the core-facing buses, key word0 on top
  always_comb begin
    ch_src  = '0;
    ch_dst  = '0;
    ch_size = '0;
    ch_key  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch_src[32*c +: 32]  = src_q[c];
      ch_dst[32*c +: 32]  = dst_q[c];
      ch_size[32*c +: 32] = size_q[c];
      for (int k = 0; k < KEY_WORDS; k++) begin
        ch_key[32*(c*KEY_WORDS + KEY_WORDS-1-k) +: 32] = key_q[c][k];
      end
    end
  end

  assign ch_start   = start_q;
  assign ch_decrypt = dec_q;

endmodule

// File: tb/tb_aes_ahb_regbank.sv
// tb_aes_ahb_regbank: directed plus random AHB traffic
// checked against a register-level reference model.
module tb_aes_ahb_regbank;

  localparam int NCH = 2;
  localparam int KW  = 4;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  logic hsel = 1'b0;
  logic hwrite = 1'b0;
  logic hready;
  logic [31:0] haddr = '0;
  logic [31:0] hwdata = '0;
  logic [1:0] htrans = 2'b00;
  logic [2:0] hsize = 3'b010;
  logic hreadyout, hresp;
  logic [31:0] hrdata;
  logic [NCH-1:0] ch_start, ch_decrypt;
  logic [NCH-1:0] core_done = '0;
  logic [NCH-1:0] core_err = '0;
  logic [32*NCH-1:0] ch_src, ch_dst, ch_size;
  logic [32*KW*NCH-1:0] ch_key;
  logic irq;

  assign hready = hreadyout;
  always #5 hclk = ~hclk;

  aes_ahb_regbank #(
    .BASE_HI(23'h0), .NUM_CH(NCH), .KEY_WORDS(KW)
  ) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hready(hready), .hwdata(hwdata),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .ch_start(ch_start), .ch_src(ch_src), .ch_dst(ch_dst),
    .ch_key(ch_key), .ch_size(ch_size),
    .ch_decrypt(ch_decrypt), .core_done(core_done),
    .core_err(core_err), .irq(irq)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_src [NCH];
  logic [31:0] m_dst [NCH];
  logic [31:0] m_size [NCH];
  logic [31:0] m_key [NCH][KW];
  logic [NCH-1:0] m_dec, m_ien, m_busy, m_done, m_err;

  logic [31:0] kv [4];
  int otab [12];

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_src[c] = '0;
      m_dst[c] = '0;
      m_size[c] = '0;
      for (int k = 0; k < KW; k++) m_key[c][k] = '0;
    end
    m_dec = '0; m_ien = '0;
    m_busy = '0; m_done = '0; m_err = '0;
  endtask

  task automatic model_core(input logic [NCH-1:0] d, input logic [NCH-1:0] e,
                            input logic [NCH-1:0] st);
    for (int c = 0; c < NCH; c++) begin
      if ((d[c] || e[c]) && !st[c]) m_busy[c] = 1'b0;
      if (d[c]) m_done[c] = 1'b1;
      if (e[c]) m_err[c] = 1'b1;
    end
  endtask

  task automatic model_xfer(input logic [31:0] a, input logic w,
                            input logic [2:0] sz, input logic [31:0] wd,
                            output logic e, output logic [31:0] rd,
                            output logic [NCH-1:0] st);
    int ch, off;
    bit iskey, mapped;
    ch = int'(a[8:0]) / 64;
    off = int'(a[8:0]) % 64;
    iskey = off >= 8 && off < 8 + 4*KW && off % 4 == 0;
    mapped = off == 0 || off == 4 || iskey || off == 40 ||
             off == 44 || off == 48;
    e = (a[31:9] != 23'd0) || ch >= NCH || !mapped || sz != 3'd2;
    rd = '0;
    st = '0;
    if (!e && w && off != 48 && m_busy[ch]) begin
      e = 1'b1;
      m_err[ch] = 1'b1;
    end
    if (e) return;
    if (!w) begin
      case (off)
        0:  rd = m_src[ch];
        4:  rd = m_dst[ch];
        40: rd = m_size[ch];
        44: rd = {29'd0, m_ien[ch], m_dec[ch], 1'b0};
        48: rd = {29'd0, m_err[ch], m_done[ch], m_busy[ch]};
        default: rd = m_key[ch][(off - 8) / 4];
      endcase
    end else begin
      case (off)
        0:  m_src[ch] = wd;
        4:  m_dst[ch] = wd;
        40: m_size[ch] = wd;
        44: begin
          m_dec[ch] = wd[1];
          m_ien[ch] = wd[2];
          if (wd[0]) begin
            m_busy[ch] = 1'b1;
            st[ch] = 1'b1;
          end
        end
        48: begin
          if (wd[1]) m_done[ch] = 1'b0;
          if (wd[2]) m_err[ch] = 1'b0;
        end
        default: m_key[ch][(off - 8) / 4] = wd;
      endcase
    end
  endtask

  task automatic xfer(input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic [NCH-1:0] dd, input logic [NCH-1:0] de,
                      output logic [31:0] rd, output logic [1:0] rsp,
                      output int wt);
    hsel = 1'b1; haddr = a; htrans = 2'b10;
    hwrite = w; hsize = sz;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    core_done = dd; core_err = de;
    wt = 0;
    rsp[1] = hresp;
    while (!hreadyout && wt < 8) begin
      @(posedge hclk); #1;
      core_done = '0; core_err = '0;
      wt++;
    end
    rsp[0] = hresp;
    rd = hrdata;
    @(posedge hclk); #1;
    core_done = '0; core_err = '0;
  endtask

  task automatic bus(input logic [31:0] a, input logic w,
                     input logic [2:0] sz, input logic [31:0] wd,
                     input logic [NCH-1:0] dd, input logic [NCH-1:0] de,
                     output logic [31:0] rd);
    logic e;
    logic [31:0] erd;
    logic [NCH-1:0] est;
    logic [1:0] rsp;
    int wt;
    model_xfer(a, w, sz, wd, e, erd, est);
    model_core(dd, de, est);
    xfer(a, w, sz, wd, dd, de, rd, rsp, wt);
    chk("resp", 128'(rsp), 128'({e, e}));
    chk("waits", 128'(wt), (e || !w) ? 128'd1 : 128'd0);
    if (!w && !e) chk("rdata", 128'(rd), 128'(erd));
    chk("start", 128'(ch_start), 128'(est));
  endtask

  task automatic core_pulse(input logic [NCH-1:0] d, input logic [NCH-1:0] e);
    core_done = d; core_err = e;
    model_core(d, e, '0);
    @(posedge hclk); #1;
    core_done = '0; core_err = '0;
  endtask

  task automatic check_regs();
    logic [127:0] kc;
    @(posedge hclk); #1;
    for (int c = 0; c < NCH; c++) begin
      chk("src", 128'(ch_src[32*c +: 32]), 128'(m_src[c]));
      chk("dst", 128'(ch_dst[32*c +: 32]), 128'(m_dst[c]));
      chk("size", 128'(ch_size[32*c +: 32]), 128'(m_size[c]));
      kc = '0;
      for (int k = 0; k < KW; k++) kc = {kc[95:0], m_key[c][k]};
      chk("key", ch_key[128*c +: 128], kc);
    end
    chk("dec", 128'(ch_decrypt), 128'(m_dec));
    chk("irq", 128'(irq), 128'(|(m_ien & (m_done | m_err))));
    chk("start_idle", 128'(ch_start), 128'd0);
  endtask

  initial begin
    logic [31:0] rd, a, wd, r;
    logic w;
    logic [2:0] sz;
    logic [NCH-1:0] dd, de;
    int ch, off;

    kv = '{32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
    otab = '{0, 4, 8, 12, 16, 20, 40, 44, 44, 48, 48, 0};
    model_reset();

    repeat (2) @(posedge hclk);
    #1 hresetn = 1'b1;
    chk("rst_ready", 128'(hreadyout), 128'd1);
    chk("rst_resp", 128'(hresp), 128'd0);
    chk("rst_rdata", 128'(hrdata), 128'd0);
    chk("rst_start", 128'(ch_start), 128'd0);
    chk("rst_irq", 128'(irq), 128'd0);

    bus(32'h030, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    chk("st0_rst", 128'(rd), 128'd0);
    chk("irq_rst", 128'(irq), 128'd0);

    for (int k = 0; k < 4; k++)
      bus(32'h048 + 32'(4*k), 1'b1, 3'd2, kv[k], '0, '0, rd);
    chk("key1", ch_key[255:128],
        128'h00112233_44556677_8899AABB_CCDDEEFF);
    for (int k = 0; k < 4; k++) begin
      bus(32'h048 + 32'(4*k), 1'b0, 3'd2, 32'h0, '0, '0, rd);
      chk("key1_rd", 128'(rd), 128'(kv[k]));
    end

    bus(32'h02C, 1'b1, 3'd2, 32'h5, '0, '0, rd);
    chk("start0", 128'(ch_start), 128'd1);
    check_regs();
    bus(32'h030, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    chk("st_busy", 128'(rd), 128'd1);
    bus(32'h000, 1'b1, 3'd2, 32'hDEADBEEF, '0, '0, rd);
    chk("src_lock", 128'(ch_src[31:0]), 128'd0);
    bus(32'h030, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    chk("st_lock", 128'(rd), 128'd5);
    core_pulse(2'b01, 2'b00);
    bus(32'h030, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    chk("st_done", 128'(rd), 128'd6);
    check_regs();
    chk("irq_done", 128'(irq), 128'd1);
    bus(32'h030, 1'b1, 3'd2, 32'h6, '0, '0, rd);
    chk("irq_lag", 128'(irq), 128'd1);
    bus(32'h030, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    chk("st_w1c", 128'(rd), 128'd0);
    check_regs();
    chk("irq_clr", 128'(irq), 128'd0);

    bus(32'h0FC, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    bus(32'h000, 1'b1, 3'd1, 32'h1234, '0, '0, rd);
    check_regs();
    chk("src_half", 128'(ch_src[31:0]), 128'd0);

    core_pulse(2'b10, 2'b00);
    bus(32'h070, 1'b1, 3'd2, 32'h2, 2'b10, 2'b00, rd);
    bus(32'h070, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    chk("done_keep", 128'(rd), 128'd2);

    bus(32'h02C, 1'b1, 3'd2, 32'h1, 2'b01, 2'b00, rd);
    bus(32'h030, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    chk("start_done", 128'(rd), 128'd3);
    core_pulse(2'b01, 2'b00);
    bus(32'h030, 1'b1, 3'd2, 32'h6, '0, '0, rd);

    hsel = 1'b1; haddr = 32'h028; htrans = 2'b10;
    hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hwdata = 32'h00001000; hwrite = 1'b0;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    chk("b2b_wait", 128'(hreadyout), 128'd0);
    @(posedge hclk); #1;
    chk("b2b_ready", 128'(hreadyout), 128'd1);
    chk("b2b_resp", 128'(hresp), 128'd0);
    chk("b2b_rdata", 128'(hrdata), 128'h1000);
    @(posedge hclk); #1;
    m_size[0] = 32'h00001000;
    check_regs();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom;
        dd = r[NCH-1:0];
        de = ($urandom_range(0, 2) == 0) ? r[NCH+1:NCH] : '0;
        core_pulse(dd, de);
      end
      ch = $urandom_range(0, 2);
      off = otab[$urandom_range(0, 11)];
      if ($urandom_range(0, 11) == 0) off = $urandom_range(0, 63);
      a = 32'(ch*64 + off);
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom;
        a[31:9] = r[22:0];
      end
      w = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      wd = $urandom;
      if (off == 44 && $urandom_range(0, 1) == 1) wd[0] = 1'b1;
      r = $urandom;
      dd = ($urandom_range(0, 9) == 0) ? r[NCH-1:0] : '0;
      de = ($urandom_range(0, 19) == 0) ? r[NCH+1:NCH] : '0;
      bus(a, w, sz, wd, dd, de, rd);
      if (i % 8 == 7) check_regs();
    end

    core_pulse(2'b11, 2'b00);
    hsel = 1'b1; haddr = 32'h06C; htrans = 2'b10;
    hwrite = 1'b1; hsize = 3'd2;
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1;
    hresetn = 1'b0;
    #2;
    chk("rstmid_ready", 128'(hreadyout), 128'd1);
    chk("rstmid_resp", 128'(hresp), 128'd0);
    @(posedge hclk); #1;
    chk("rstmid_start", 128'(ch_start), 128'd0);
    hresetn = 1'b1;
    model_reset();
    bus(32'h070, 1'b0, 3'd2, 32'h0, '0, '0, rd);
    chk("rstmid_st", 128'(rd), 128'd0);
    check_regs();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/aes_ahb_regbank.md
Name: aes_ahb_regbank

Overview:
Parametrised AHB-Lite slave register bank for the AES accelerator. It holds NUM_CH independent job descriptors (source address, destination address, key, size, control) and issues start pulses to the AES/DMA core. It tracks per-channel BUSY/DONE/ERR status and drives a combined interrupt. It replaces the single-channel, fixed-128-bit-key register block and adds proper address/data phase pipelining, wait states and ERROR responses.

Parameters:
BASE_HI, 23'h0, value haddr[31:9] must equal for the slave to be addressed
NUM_CH, 2, number of descriptor channels (1..4)
KEY_WORDS, 4, key length in 32-bit words (4, 6 or 8; AES-128/192/256)

Ports:
hclk  in  1  AHB clock
hresetn  in  1  reset, asynchronous, active-low
hsel  in  1  slave select
haddr  in  32  address (address phase)
htrans  in  2  transfer type; NONSEQ=2, SEQ=3 are valid
hwrite  in  1  1=write
hsize  in  3  transfer size; only 3'b010 (word) legal
hready  in  1  bus ready (previous data phase complete)
hwdata  in  32  write data (data phase)
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  read data
ch_start  out  NUM_CH  one-cycle start pulse per channel
ch_src  out  32*NUM_CH  SRC_ADDR per channel
ch_dst  out  32*NUM_CH  DST_ADDR per channel
ch_key  out  32*KEY_WORDS*NUM_CH  key per channel; word0 is the MSW
ch_size  out  32*NUM_CH  SIZE per channel
ch_decrypt  out  NUM_CH  CTRL.DECRYPT per channel
core_done  in  NUM_CH  per-channel completion pulse from core
core_err  in  NUM_CH  per-channel error pulse from core
irq  out  1  combined interrupt

Behaviour:
- Reset: every register and output 0; hreadyout=1, hresp=0, hrdata=0, ch_start=0, irq=0.
- Address phase: a transfer is accepted when hsel & hready & htrans[1]. Register haddr, hwrite and hsize on that edge. Any other case is idle, and the slave returns OKAY with zero wait states.
- Channel c window: haddr[8:0] = c*0x40 + off.
  - off 0x00 SRC_ADDR; 0x04 DST_ADDR; 0x08+4k KEY[k] for k<KEY_WORDS; 0x28 SIZE.
  - off 0x2C CTRL: bit0 START (write-1, self-clearing, reads 0), bit1 DECRYPT, bit2 IRQ_EN.
  - off 0x30 STATUS: bit0 BUSY RO, bit1 DONE W1C, bit2 ERR W1C.
  - Unlisted bits read 0.
- Decode error: haddr[31:9]!=BASE_HI, channel index >=NUM_CH, unmapped offset, or hsize!=word.
- Data-phase FSM states: IDLE, WR, RD_WAIT, RD, ERR1, ERR2.
  - Write: zero wait; the register updates from hwdata at the end of the data phase (hreadyout=1).
  - Read: one wait state. RD_WAIT drives hreadyout=0; hrdata is registered; RD drives hreadyout=1 with valid hrdata.
  - ERROR: ERR1 drives hresp=1, hreadyout=0; ERR2 drives hresp=1, hreadyout=1; then IDLE, or a new accepted transfer.
- Busy lock: a write to SRC/DST/KEY/SIZE/CTRL of a channel with BUSY=1 returns ERROR, is discarded, and sets that channel's ERR.
- START: a write with bit0=1 to an idle channel gives a ch_start[c] pulse one cycle after the data phase and sets BUSY.
- core_done[c]: clears BUSY, sets DONE. core_err[c]: clears BUSY, sets ERR.
- Priority on the same edge: a hardware set of DONE/ERR beats a software W1C clear. core_done in the same cycle as a START write to that channel gives BUSY=1, DONE=1.
- irq = OR over c of IRQ_EN[c] & (DONE[c] | ERR[c]). Registered, so it appears one cycle after the status change.
- Reset mid-transfer: the FSM returns to IDLE immediately, and no partial write or start is committed.

Test Plan:
- Reset, then read ch0 STATUS @0x030 -> one wait state, hrdata=0, hresp=0, irq=0.
- Write ch1 KEY0..3 = 0x00112233/44556677/8899AABB/CCDDEEFF @0x048..0x054 -> ch_key for ch1 = 128'h00112233_44556677_8899AABB_CCDDEEFF; readback matches.
- Write CTRL=0x5 to ch0 -> ch_start[0] pulses one cycle, STATUS=0x1. Write SRC while busy -> two-cycle ERROR, SRC unchanged, STATUS=0x5. core_done[0] -> STATUS=0x6, irq=1. W1C 0x6 -> STATUS=0, irq=0.
- Read @0x0FC (unmapped), then a halfword write (hsize=1) to 0x000 -> each gets a 2-cycle ERROR (hresp=1, hreadyout 0 then 1); no register changes.
- core_done[1] in the same cycle as a W1C of DONE on ch1 -> DONE stays 1.
- Back-to-back NONSEQ write then read to 0x028 with data 0x00001000 -> read returns 0x00001000 after one wait state.
